// File: rtl/sys_bus_pkg.sv
// Shared system-bus definitions: direction encodings, arbiter state type and
// default bus widths used by the arbiter and the CPU bus interfaces.
package sys_bus_pkg;

    // Bus direction encoding on the rw lines
    localparam logic BUS_RD = 1'b1;
    localparam logic BUS_WR = 1'b0;

    // Default bus geometry
    localparam int unsigned MASTER_NUM_DEF    = 4;
    localparam int unsigned BUS_ADD_WIDTH_DEF = 30;
    localparam int unsigned BUS_DAT_WIDTH_DEF = 32;
    localparam int unsigned TIMEOUT_CYC_DEF   = 1024;

    // Arbiter ownership state
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sys_bus_arbiter_rr_prio_pick.sv
// rr_prio_pick: combinational round-robin picker.
// Searches req upward from last+1 (wrapping) and returns the first requester.
// Ports:
//   req   - request vector (N bits)
//   last  - index of the previous winner; it gets lowest priority
//   grant - one-hot winner (zero when no request)
//   idx   - index of the winner (zero when no request)
//   valid - at least one request present
module rr_prio_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Walk the N positions after last; the first hit wins
    always_comb begin
        int unsigned pos;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            pos = 32'(last) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!valid && req[IW'(pos)]) begin
                valid             = 1'b1;
                idx               = IW'(pos);
                grant[IW'(pos)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: multi-master system-bus arbiter with round-robin priority.
// A registered one-hot grant is held until the owner drops its request, then
// re-arbitrated in the same edge (back-to-back handoff). The owner's address,
// strobe, direction and write data are multiplexed onto the slave-side bus.
// Optional grant-hold timeout enabled by macro SYS_BUS_ARB_TIMEOUT_EN.
// Ports:
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   m_req_i         - per-master request
//   m_addr_i        - packed master addresses, master k at [k*AW +: AW]
//   m_as_i, m_rw_i  - per-master address strobe / direction (1=read)
//   m_wr_data_i     - packed master write data
//   m_grnt_o        - registered one-hot grant
//   s_addr_o, s_as_o, s_rw_o, s_wr_data_o - shared slave-side bus (combinational)
//   owner_o         - index of current/last owner
//   arb_err_o       - timeout revoke pulse (0 without the timeout feature)
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int unsigned MASTER_NUM    = MASTER_NUM_DEF,
    parameter int unsigned BUS_ADD_WIDTH = BUS_ADD_WIDTH_DEF,
    parameter int unsigned BUS_DAT_WIDTH = BUS_DAT_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [MASTER_NUM-1:0]               m_req_i,
    input  logic [MASTER_NUM*BUS_ADD_WIDTH-1:0] m_addr_i,
    input  logic [MASTER_NUM-1:0]               m_as_i,
    input  logic [MASTER_NUM-1:0]               m_rw_i,
    input  logic [MASTER_NUM*BUS_DAT_WIDTH-1:0] m_wr_data_i,
    output logic [MASTER_NUM-1:0]               m_grnt_o,
    output logic [BUS_ADD_WIDTH-1:0]            s_addr_o,
    output logic                                s_as_o,
    output logic                                s_rw_o,
    output logic [BUS_DAT_WIDTH-1:0]            s_wr_data_o,
    output logic [$clog2(MASTER_NUM)-1:0]       owner_o,
    output logic                                arb_err_o
);

    localparam int unsigned IW = $clog2(MASTER_NUM);
    localparam int unsigned AW = BUS_ADD_WIDTH;
    localparam int unsigned DW = BUS_DAT_WIDTH;

    // Elaboration-time parameter sanity
    if (MASTER_NUM < 2 || MASTER_NUM > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("sys_bus_arbiter: MASTER_NUM must be 2..8 and TIMEOUT_CYC >= 2");
    end

    arb_state_e            state_q, state_d;
    logic [MASTER_NUM-1:0] grnt_q,  grnt_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         last_q,  last_d;

    logic [MASTER_NUM-1:0] req_elig;
    logic [MASTER_NUM-1:0] pick_req;
    logic [MASTER_NUM-1:0] pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_valid;
    logic                  owner_req;
    logic                  revoke;

`ifdef SYS_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0]      cnt_q;
    logic [MASTER_NUM-1:0] mask_q;
    logic                  err_q;
    logic                  new_grant;

    // A revoked master stays masked until its request is seen low
    assign req_elig  = m_req_i & ~mask_q;
    assign revoke    = (state_q == ARB_OWNED) && owner_req &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // Owner is always excluded from re-arbitration, so any change is a new grant
    assign new_grant = (grnt_d != grnt_q) && (grnt_d != '0);

    // Hold counter, revoke mask and error pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= revoke;
            mask_q <= (mask_q & m_req_i) | (revoke ? grnt_q : '0);
            if (new_grant) begin
                cnt_q <= '0;
            end else if (state_q == ARB_OWNED) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign arb_err_o = err_q;
`else
    assign req_elig  = m_req_i;
    assign revoke    = 1'b0;
    assign arb_err_o = 1'b0;
`endif

    assign owner_req = |(m_req_i & grnt_q);
    // The current owner (if any) never competes in its own release
    assign pick_req  = req_elig & ~grnt_q;

    rr_prio_pick #(
        .N  (MASTER_NUM),
        .IW (IW)
    ) u_pick (
        .req   (pick_req),
        .last  (last_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // State and grant registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            grnt_q  <= '0;
            owner_q <= '0;
            last_q  <= IW'(MASTER_NUM - 1);
        end else begin
            state_q <= state_d;
            grnt_q  <= grnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant on request, hold while owner requests, re-arbitrate on release
    always_comb begin
        state_d = state_q;
        grnt_d  = grnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_OWNED;
                    grnt_d  = pick_grant;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                end
            end
            ARB_OWNED: begin
                if (!owner_req || revoke) begin
                    if (pick_valid) begin
                        grnt_d  = pick_grant;
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        grnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grnt_d  = '0;
            end
        endcase
    end

    // Slave-side mux: AND-OR select by the one-hot grant; idle bus when ungranted
    always_comb begin
        logic rw_sel;
        s_addr_o    = '0;
        s_wr_data_o = '0;
        s_as_o      = 1'b0;
        rw_sel      = BUS_RD;
        for (int unsigned k = 0; k < MASTER_NUM; k++) begin
            if (grnt_q[k]) begin
                s_addr_o    = m_addr_i[k*AW +: AW];
                s_wr_data_o = m_wr_data_i[k*DW +: DW];
                s_as_o      = m_as_i[k];
                rw_sel      = m_rw_i[k];
            end
        end
        s_rw_o = rw_sel;
    end

    assign m_grnt_o = grnt_q;
    assign owner_o  = owner_q;

endmodule
